// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks while locked, restartable.
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic inclk0,
    input  logic areset_n,
    input  logic i_locked,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Terminal count at zero, so a restart yields its first tick one cycle later.
    assign o_tick = i_locked && !i_restart && (r_cnt == '0);

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            r_cnt <= '0;
        end else if (!i_locked || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver gated by PLL lock, feeding a one-deep valid/ready buffer.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling DATA_BITS payload bits, LSB first
// PARITY | sampling the even-parity bit (parity builds only)
// STOP   | sampling the stop bit, then back to IDLE
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 inclk0,
    input  logic                 areset_n,
    input  logic                 locked,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_FULL  = OSW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_core: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_bits
        $error("uart_rx_core: DATA_BITS must be in 5..8");
    end

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t ST_AFTER_DATA = PARITY;
`else
    localparam rx_state_t ST_AFTER_DATA = STOP;
`endif

    logic [1:0]           r_sync;
    logic                 r_rxd_prev;
    rx_state_t            r_state;
    logic [OSW-1:0]       r_os_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    logic w_rxd_s;
    logic w_tick;
    logic w_start;
    logic w_sample;
    logic w_stop_done;
    logic w_par_ok;
    logic w_good;

    assign w_rxd_s     = r_sync[1];
    assign w_start     = (r_state == IDLE) && locked && r_rxd_prev && !w_rxd_s;
    assign w_sample    = w_tick && (r_os_cnt == '0) && (r_state != IDLE);
    assign w_stop_done = w_sample && (r_state == STOP);
    assign w_good      = w_stop_done && w_rxd_s && w_par_ok;

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .inclk0    (inclk0),
        .areset_n  (areset_n),
        .i_locked  (locked),
        .i_restart (w_start),
        .o_tick    (w_tick)
    );

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            r_sync     <= {2{UART_IDLE_LEVEL}};
            r_rxd_prev <= UART_IDLE_LEVEL;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxd_prev <= w_rxd_s;
        end
    end

    // r_os_cnt counts down the ticks remaining until the next mid-bit sample.
    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (!locked) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
        end else if (w_start) begin
            r_state  <= START;
            r_os_cnt <= OS_HALF;
        end else if (w_tick && (r_state != IDLE)) begin
            if (r_os_cnt != '0) begin
                r_os_cnt <= r_os_cnt - 1'b1;
            end else begin
                r_os_cnt <= OS_FULL;
                case (r_state)
                    START: begin
                        if (w_rxd_s) begin
                            r_state  <= IDLE;
                            r_os_cnt <= '0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= ST_AFTER_DATA;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        r_state <= STOP;
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_os_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            r_par_err <= 1'b0;
        end else if (w_start) begin
            r_par_err <= 1'b0;
        end else if (w_sample && (r_state == PARITY)) begin
            r_par_err <= w_rxd_s ^ (^r_shift);
        end
    end

    assign w_par_ok = !r_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    // A consumer read in the completion cycle frees the slot for the new byte.
    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_done && !(w_rxd_s && w_par_ok);
            overrun   <= w_good && rx_valid && !rx_ready;
            if (w_good && (!rx_valid || rx_ready)) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus random frames against a byte-queue scoreboard.
module tb_uart_rx_core;

    localparam int BIT_CYC = 16;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_MID = 9 + 16 * 10;
`else
    localparam int STOP_MID = 9 + 16 * 9;
`endif

    logic       inclk0   = 1'b0;
    logic       areset_n = 1'b0;
    logic       locked   = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int ferr_cyc  = 0;
    int ovr_cyc   = 0;
    int valid_cyc = 0;
    logic [7:0] exp_q[$];
    logic rand_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif

    uart_rx_core dut (
        .inclk0    (inclk0),
        .areset_n  (areset_n),
        .locked    (locked),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 inclk0 = ~inclk0;

    always @(posedge inclk0) cyc <= cyc + 1;

    always @(negedge inclk0) begin
        if (frame_err) ferr_cyc++;
        if (overrun)   ovr_cyc++;
        if (rx_valid)  valid_cyc++;
        if (areset_n && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rx: got %02h, nothing expected", rx_data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge inclk0);
            #1;
        end
    endtask

    task automatic to_cyc(input int k);
        while (cyc < k) begin
            @(posedge inclk0);
            #1;
        end
    endtask

    task automatic wait_cyc(input int k);
        to_cyc(k);
        @(negedge inclk0);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        tick_n(BIT_CYC);
    endtask

    // abort_at >= 0 stops the frame halfway through that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int abort_at);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                rxd = d[i];
                tick_n(BIT_CYC / 2);
                return;
            end
            drive_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        drive_bit(stop_b);
        rxd = 1'b1;
    endtask

    initial begin
        #500_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n, f0, v0, o0, n_bad;
        logic [7:0] d;
        logic bad;

        tick_n(5);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_ovr", overrun, 0);
        areset_n = 1'b1;
        tick_n(5);

        // PLL not locked: the line is ignored.
        rx_ready = 1'b1;
        v0 = valid_cyc;
        send_frame(8'hA5, 1'b1, -1);
        tick_n(20);
        chk("unlocked_no_valid", valid_cyc - v0, 0);
        locked = 1'b1;
        tick_n(10);
        exp_q.push_back(8'hA5);
        n = cyc + 1;
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                wait_cyc(n + STOP_MID);
                chk("valid_at_stop_mid", rx_valid, 0);
                wait_cyc(n + STOP_MID + 1);
                chk("valid_after_stop_mid", rx_valid, 1);
                chk("data_after_stop_mid", rx_data, 8'hA5);
            end
        join
        tick_n(20);

        // Short low glitch.
        f0 = ferr_cyc;
        v0 = valid_cyc;
        rxd = 1'b0;
        tick_n(4);
        rxd = 1'b1;
        tick_n(40);
        chk("glitch_no_valid", valid_cyc - v0, 0);
        chk("glitch_no_ferr", ferr_cyc - f0, 0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, -1);
        tick_n(20);

        // Stop bit low.
        f0 = ferr_cyc;
        v0 = valid_cyc;
        send_frame(8'h3C, 1'b0, -1);
        tick_n(20);
        chk("ferr_one_cycle", ferr_cyc - f0, 1);
        chk("ferr_no_valid", valid_cyc - v0, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        tick_n(20);

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        o0 = ovr_cyc;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        tick_n(20);
        chk("ovr_one_pulse", ovr_cyc - o0, 1);
        chk("ovr_valid_held", rx_valid, 1);
        chk("ovr_old_data_kept", rx_data, 8'h11);
        rx_ready = 1'b1;
        tick_n(1);
        rx_ready = 1'b0;
        @(negedge inclk0);
        chk("ovr_drained", rx_valid, 0);

        // Consumer reads in the exact completion cycle: no overrun.
        o0 = ovr_cyc;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_frame(8'h33, 1'b1, -1);
        n = cyc + 1;
        fork
            send_frame(8'h44, 1'b1, -1);
            begin
                to_cyc(n + STOP_MID);
                rx_ready = 1'b1;
                tick_n(1);
                rx_ready = 1'b0;
            end
        join
        tick_n(10);
        chk("same_cycle_no_ovr", ovr_cyc - o0, 0);
        chk("same_cycle_valid", rx_valid, 1);
        chk("same_cycle_data", rx_data, 8'h44);
        rx_ready = 1'b1;
        tick_n(3);

        // Asynchronous reset in the middle of a frame, with a byte still buffered.
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, -1);
        tick_n(10);
        chk("pre_reset_valid", rx_valid, 1);
        send_frame(8'hFF, 1'b1, 4);
        areset_n = 1'b0;
        #1;
        chk("async_rst_valid", rx_valid, 0);
        chk("async_rst_data", rx_data, 0);
        chk("async_rst_ferr", frame_err, 0);
        chk("async_rst_ovr", overrun, 0);
        rxd = 1'b1;
        tick_n(3);
        areset_n = 1'b1;
        tick_n(10);
        rx_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        tick_n(20);

        // PLL loses lock mid-frame.
        f0 = ferr_cyc;
        o0 = ovr_cyc;
        v0 = valid_cyc;
        send_frame(8'h00, 1'b1, 4);
        locked = 1'b0;
        rxd = 1'b1;
        tick_n(20);
        locked = 1'b1;
        tick_n(200);
        chk("unlock_no_ferr", ferr_cyc - f0, 0);
        chk("unlock_no_ovr", ovr_cyc - o0, 0);
        chk("unlock_no_valid", valid_cyc - v0, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1);
        tick_n(20);

`ifdef UART_RX_PARITY_EN
        f0 = ferr_cyc;
        exp_q.push_back(8'h07);
        bad_par = 1'b0;
        send_frame(8'h07, 1'b1, -1);
        tick_n(20);
        chk("parity_ok_no_ferr", ferr_cyc - f0, 0);
        v0 = valid_cyc;
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1, -1);
        bad_par = 1'b0;
        tick_n(20);
        chk("parity_bad_ferr", ferr_cyc - f0, 1);
        chk("parity_bad_no_valid", valid_cyc - v0, 0);
`endif

        // Random frames, random gaps, random consumer stalls.
        f0 = ferr_cyc;
        o0 = ovr_cyc;
        n_bad = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    d   = 8'($urandom);
                    bad = ($urandom_range(0, 5) == 0);
                    if (bad) n_bad++;
                    else exp_q.push_back(d);
                    send_frame(d, !bad, -1);
                    tick_n(bad ? $urandom_range(4, 30) : $urandom_range(0, 30));
                end
                tick_n(40);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    tick_n(1);
                end
            end
        join
        rx_ready = 1'b1;
        tick_n(5);
        chk("rand_ferr_count", ferr_cyc - f0, n_bad);
        chk("rand_no_ovr", ovr_cyc - o0, 0);
        chk("all_bytes_received", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
